pipeline_hazard_unit: RTL and testbench
=======================================

# pipeline_hazard_unit

Hazard and flush controller for the five-stage RISC-V pipeline. It detects load-use hazards between ID and EX and holds PC and IF/ID while bubbling ID/EX. It also flushes IF/ID and ID/EX on a taken branch or jump resolved in EX, and drives EX-stage operand forwarding selects. It sits between the decode stage and the ID/EX register and consumes the ID/EX, EX/MEM and MEM/WB register outputs. Saturating stall and flush counters support performance analysis.

## Interface
- LOAD_LATENCY, 1: bubble cycles inserted per load-use hazard (1..7).
- CNT_W, 32: width of each performance counter.

- clk  in  1  clock; all state updates on the falling edge, the same edge as the pipeline registers.
- rst  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads that source.
- ex_rs1, ex_rs2  in  5 each  rs1_out/rs2_out of ID/EX.
- ex_rd  in  5  rd_out of ID/EX.
- ex_load  in  1  load_out of ID/EX.
- ex_branch_taken  in  1  NextPCSrc resolved in EX.
- mem_rd  in  5  rd of EX/MEM.
- mem_we, mem_load  in  1 each  EX/MEM write enable and load flag.
- wb_rd  in  5  rd of MEM/WB.
- wb_we  in  1  MEM/WB write enable.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  zero IF/ID.
- idex_bubble  out  1  hazard_detection into ID/EX; zero its control fields.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 MEM/WB, 10 EX/MEM.
- stall_cycles  out  CNT_W  cycles with pc_stall high, saturating.
- flush_events  out  CNT_W  taken-branch flushes, saturating.

## Operation
- lu_hit is high when ex_load=1, ex_rd≠0, and ex_rd matches id_rs1 with id_use_rs1 set or id_rs2 with id_use_rs2 set.
- States:
  - RUN: idle state.
  - LSTALL: carries down-counter rem (3 bits).
- RUN:
  - If ex_branch_taken=1: ifid_flush=1 and idex_bubble=1. No stall. flush_events increments. Stay in RUN.
  - Else if lu_hit=1: pc_stall, ifid_stall and idex_bubble are all 1. If LOAD_LATENCY>1, go to LSTALL with rem=LOAD_LATENCY-1. Otherwise stay in RUN.
- LSTALL:
  - pc_stall, ifid_stall and idex_bubble are 1 regardless of lu_hit.
  - rem decrements each edge. Leave for RUN on the edge where rem=1.
  - If ex_branch_taken=1 occurs here, the flush wins: flush outputs as in RUN, no stall, and the state goes to RUN immediately.
- Branch has priority over load-use in every state, so a flush is never accompanied by a stall.
- Forwarding (combinational, independent of state), shown for fwd_a; fwd_b is the same using ex_rs2:
  - 10 if mem_we=1, mem_load=0, mem_rd≠0 and mem_rd=ex_rs1.
  - Else 01 if wb_we=1, wb_rd≠0 and wb_rd=ex_rs1.
  - Else 00.
- Register x0 never triggers a hazard or forwarding.
- Counters:
  - stall_cycles increments on each edge where pc_stall=1.
  - Both counters stop at 2^CNT_W-1.
  - cnt_clr has priority over increment.

## Timing
- All stall, flush and fwd outputs are combinational from inputs and state, valid within the same cycle for the pipeline registers' next falling edge.
- Load-use penalty is exactly LOAD_LATENCY cycles of pc_stall.
- Reset (rst=0), effective immediately:
  - State is RUN, rem=0, both counters 0.
  - pc_stall, ifid_stall, ifid_flush, idex_bubble and fwd_a/fwd_b are forced to 0 while rst=0.
- Reset asserted mid-LSTALL aborts the stall at once. There is no residual bubble after release.
- The first falling edge after rst rises evaluates from RUN.

## Test plan
- lw x5 then add x6,x5,x1, LOAD_LATENCY=1 -> exactly one cycle of pc_stall/ifid_stall/idex_bubble; stall_cycles=1; then fwd_a=01 for the add in EX.
- Same sequence with LOAD_LATENCY=3 -> three consecutive stall cycles, state LSTALL for two edges, stall_cycles=3.
- lw x0 followed by a reader of x0, and lw x5 followed by an instruction with id_use_rs1=0 -> no stall.
- ex_branch_taken=1 coincident with lu_hit=1 -> ifid_flush=1, idex_bubble=1, pc_stall=0; flush_events=1.
- add x5 then sub x7,x5,x5 with x5 also in MEM/WB -> fwd_a=fwd_b=10 (EX/MEM wins); with mem_load=1 instead -> 01.
- Assert rst low during the second LSTALL cycle -> all outputs 0 immediately and counters 0; after release, no stall until a new lu_hit.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, taken-branch flush and EX operand forwarding control for the
// five-stage pipeline, with saturating stall/flush performance counters.
module pipeline_hazard_unit #(
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_we,
  input  logic             mem_load,
  input  logic [4:0]       wb_rd,
  input  logic             wb_we,
  input  logic             cnt_clr,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned REM_W = 3;

  typedef enum logic {RUN, LSTALL} state_t;

  state_t           state, state_nx;
  logic [REM_W-1:0] rem, rem_nx;
  logic             lu_hit;

  assign lu_hit = ex_load && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (ex_rd == id_rs1)) ||
                   (id_use_rs2 && (ex_rd == id_rs2)));

  // EX/MEM wins over MEM/WB; a load in EX/MEM has no data yet to forward
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_we && !mem_load && (mem_rd != 5'd0) && (mem_rd == src))
      return 2'b10;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      rem   <= '0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
    end
  end

  // Branch flush always beats any stall, in either state
  always_comb begin
    state_nx    = state;
    rem_nx      = rem;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (rst) begin
      fwd_a = fwd_sel(ex_rs1);
      fwd_b = fwd_sel(ex_rs2);
      if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        state_nx    = RUN;
        rem_nx      = '0;
      end else if (state == LSTALL) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
        rem_nx      = rem - REM_W'(1);
        if (rem == REM_W'(1)) begin
          state_nx = RUN;
        end
      end else if (lu_hit) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
        if (LOAD_LATENCY > 1) begin
          state_nx = LSTALL;
          rem_nx   = REM_W'(LOAD_LATENCY - 1);
        end
      end
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (cnt_clr) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (ifid_flush && (flush_events != '1)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: two instances (LOAD_LATENCY 1 and 3, the
// latter with narrow counters) share stimulus and are checked against a model.
module tb_pipeline_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_load, ex_branch_taken;
  logic       mem_we, mem_load, wb_we, cnt_clr;

  logic        a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_bubble;
  logic [1:0]  a_fwd_a, a_fwd_b;
  logic [31:0] a_stall_cycles, a_flush_events;
  logic        b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_bubble;
  logic [1:0]  b_fwd_a, b_fwd_b;
  logic [3:0]  b_stall_cycles, b_flush_events;

  int tests;
  int fails;

  // model state per instance: remaining forced-stall cycles and counters
  int     left [2];
  longint scnt [2];
  longint fcnt [2];
  int     ll   [2];
  longint cmax [2];

  logic [7:0]  ctrl [2];
  logic [63:0] sc   [2];
  logic [63:0] fc   [2];

  pipeline_hazard_unit #(.LOAD_LATENCY(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_load(ex_load),
    .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_load(mem_load),
    .wb_rd(wb_rd), .wb_we(wb_we), .cnt_clr(cnt_clr),
    .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall), .ifid_flush(a_ifid_flush),
    .idex_bubble(a_idex_bubble), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
    .stall_cycles(a_stall_cycles), .flush_events(a_flush_events)
  );

  pipeline_hazard_unit #(.LOAD_LATENCY(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_load(ex_load),
    .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_load(mem_load),
    .wb_rd(wb_rd), .wb_we(wb_we), .cnt_clr(cnt_clr),
    .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall), .ifid_flush(b_ifid_flush),
    .idex_bubble(b_idex_bubble), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
    .stall_cycles(b_stall_cycles), .flush_events(b_flush_events)
  );

  assign ctrl[0] = {a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_bubble, a_fwd_a, a_fwd_b};
  assign ctrl[1] = {b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_bubble, b_fwd_a, b_fwd_b};
  assign sc[0] = 64'(a_stall_cycles);
  assign sc[1] = 64'(b_stall_cycles);
  assign fc[0] = 64'(a_flush_events);
  assign fc[1] = 64'(b_flush_events);

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic logic model_lu();
    return ex_load && (ex_rd != 0) &&
           ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (src != 0 && mem_we && !mem_load && mem_rd == src) return 2'd2;
    if (src != 0 && wb_we && wb_rd == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic model_stalling(input int d);
    return !ex_branch_taken && (left[d] > 0 || model_lu());
  endfunction

  function automatic logic [7:0] model_ctrl(input int d);
    logic st;
    if (!rst) return 8'd0;
    st = model_stalling(d);
    return {st, st, ex_branch_taken, st | ex_branch_taken,
            model_fwd(ex_rs1), model_fwd(ex_rs2)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s/ctrl%0d", tag, d), 64'(ctrl[d]), 64'(model_ctrl(d)));
      check($sformatf("%s/stall_cnt%0d", tag, d), sc[d], 64'(scnt[d]));
      check($sformatf("%s/flush_cnt%0d", tag, d), fc[d], 64'(fcnt[d]));
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      left[d] = 0;
      scnt[d] = 0;
      fcnt[d] = 0;
    end
  endtask

  // check mid-cycle, then advance the model across the active falling edge
  task automatic cycle(input string tag);
    logic st [2];
    logic lu;
    @(posedge clk);
    check_all(tag);
    lu = model_lu();
    for (int d = 0; d < 2; d++) st[d] = model_stalling(d);
    @(negedge clk);
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        if (cnt_clr) begin
          scnt[d] = 0;
          fcnt[d] = 0;
        end else begin
          if (st[d] && scnt[d] < cmax[d]) scnt[d]++;
          if (ex_branch_taken && fcnt[d] < cmax[d]) fcnt[d]++;
        end
        if (ex_branch_taken) left[d] = 0;
        else if (left[d] > 0) left[d]--;
        else if (lu) left[d] = ll[d] - 1;
      end
    end else begin
      model_reset();
    end
    #1;
  endtask

  task automatic quiet();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_load = 0; ex_branch_taken = 0;
    mem_rd = 0; mem_we = 0; mem_load = 0; wb_rd = 0; wb_we = 0; cnt_clr = 0;
  endtask

  task automatic load_use_x5();
    quiet();
    ex_load = 1; ex_rd = 5;
    id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 1; id_use_rs2 = 1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    ll[0] = 1;              ll[1] = 3;
    cmax[0] = 64'hFFFF_FFFF; cmax[1] = 15;
    model_reset();
    quiet();
    rst = 0;
    #2;
    check_all("reset");
    @(negedge clk); #1;
    rst = 1;

    // lw x5 ; add x6,x5,x1 then the add reaches EX with the load in MEM/WB
    load_use_x5();
    cycle("lu_first");
    quiet(); id_rs1 = 5; id_use_rs1 = 1;
    cycle("lu_bubble1");
    cycle("lu_bubble2");
    quiet(); ex_rs1 = 5; ex_rs2 = 1; wb_rd = 5; wb_we = 1;
    cycle("add_fwd_wb");
    quiet();
    cycle("idle");

    // x0 load and an unused source never stall
    quiet(); ex_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; id_rs2 = 0; id_use_rs2 = 1;
    cycle("lw_x0");
    quiet(); ex_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 0; id_rs2 = 2; id_use_rs2 = 1;
    cycle("unused_rs1");

    // branch coincident with load-use: flush wins
    load_use_x5(); ex_branch_taken = 1;
    cycle("branch_vs_lu");
    quiet();
    cycle("after_branch");

    // EX/MEM beats MEM/WB unless the EX/MEM instruction is a load
    quiet(); ex_rs1 = 5; ex_rs2 = 5; mem_rd = 5; mem_we = 1; wb_rd = 5; wb_we = 1;
    cycle("fwd_exmem");
    mem_load = 1;
    cycle("fwd_memwb");
    mem_rd = 0; mem_load = 0; wb_rd = 0;
    cycle("fwd_x0");

    // reset during the second LSTALL cycle of the latency-3 instance
    load_use_x5();
    cycle("pre_rst_lu");
    quiet();
    @(posedge clk);
    check_all("pre_rst_stall2");
    #1 rst = 0;
    #1 model_reset();
    check_all("rst_mid_lstall");
    @(negedge clk); #1;
    rst = 1;
    cycle("post_rst_idle1");
    cycle("post_rst_idle2");

    // randomized traffic, small register range so matches are frequent
    for (int i = 0; i < 600; i++) begin
      id_rs1 = 5'($urandom_range(0, 5));
      id_rs2 = 5'($urandom_range(0, 5));
      id_use_rs1 = 1'($urandom);
      id_use_rs2 = 1'($urandom);
      ex_rs1 = 5'($urandom_range(0, 5));
      ex_rs2 = 5'($urandom_range(0, 5));
      ex_rd = 5'($urandom_range(0, 5));
      ex_load = ($urandom_range(0, 2) != 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_rd = 5'($urandom_range(0, 5));
      mem_we = 1'($urandom);
      mem_load = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 5));
      wb_we = 1'($urandom);
      cnt_clr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 99) == 0) begin
        @(posedge clk);
        #1 rst = 0;
        #1 model_reset();
        check_all("rand_rst");
        @(negedge clk); #1;
        rst = 1;
      end
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
